// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t  : EX operand source select (register file / WB result / MEM ALU result)
//   hz_state_t : mul/div sequencing states
//   REG_ADDR_W : register-index width
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MD_WAIT = 2'b01,
    MD_DONE = 2'b10
  } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding compare for one EX operand (purely combinational).
// Ports:
//   i_rs_e        source register index of the EX operand
//   i_rd_m/i_rd_w destination indices in MEM / WB
//   i_regwrite_m/i_regwrite_w  register-file write enables in MEM / WB
//   o_sel         operand source; MEM wins over WB, x0 never forwards
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_rs_e,
  input  logic [ADDR_W-1:0] i_rd_m,
  input  logic [ADDR_W-1:0] i_rd_w,
  input  logic              i_regwrite_m,
  input  logic              i_regwrite_w,
  output fwd_sel_t          o_sel
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    o_sel = FWD_RF;
    if (i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs_e)) begin
      o_sel = FWD_MEM;
    end else if (i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs_e)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline stage registers.
// Build option: define PIPE_HAZARD_MULDIV_EN to build the mul/div stall FSM and
// counter; without it muldiv_e is ignored and md_busy/stall_e/flush_m are 0.
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-low reset
//   rs1_d, rs2_d                  ID source indices (load-use detection)
//   rs1_e, rs2_e                  EX source indices (forwarding)
//   rd_e, rd_m, rd_w              destination indices in EX / MEM / WB
//   regwrite_m, regwrite_w        register-file write enables in MEM / WB
//   load_e, pcsrc_e, muldiv_e     EX holds a load / taken redirect / mul-div
//   stall_f/d/e/m                 hold for PC, IF/ID, ID/EX, EX/MEM (stall_m reserved, 0)
//   flush_d/e/m                   synchronous clear for IF/ID, ID/EX, EX/MEM
//   fwd_a_e, fwd_b_e              EX operand selects (fwd_sel_t encoding)
//   md_busy                       mul/div stall in progress
// All outputs are forced to 0 while rst is low.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int MULDIV_LAT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_m,
  input  logic                  regwrite_w,
  input  logic                  load_e,
  input  logic                  pcsrc_e,
  input  logic                  muldiv_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  md_busy
);

  import pipe_pkg::*;

  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;
  logic     w_lu;
  logic     w_md_stall;

  fwd_unit #(.ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs_e       (rs1_e),
    .i_rd_m       (rd_m),
    .i_rd_w       (rd_w),
    .i_regwrite_m (regwrite_m),
    .i_regwrite_w (regwrite_w),
    .o_sel        (w_fwd_a)
  );

  fwd_unit #(.ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs_e       (rs2_e),
    .i_rd_m       (rd_m),
    .i_rd_w       (rd_w),
    .i_regwrite_m (regwrite_m),
    .i_regwrite_w (regwrite_w),
    .o_sel        (w_fwd_b)
  );

  // Load in EX whose result is needed by the instruction in ID.
  assign w_lu = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

`ifdef PIPE_HAZARD_MULDIV_EN
  localparam int CNT_W = $clog2(MULDIV_LAT + 1);

  hz_state_t        r_state;
  hz_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // The RUN cycle that sees the mul/div already stalls, so MD_WAIT only has to
  // cover the remaining MULDIV_LAT-1 cycles: the counter is loaded with LAT-2
  // and MD_WAIT exits on the cycle it reads zero.
  assign w_md_stall = ((r_state == RUN) && muldiv_e) || (r_state == MD_WAIT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      RUN: begin
        if (muldiv_e) begin
          w_state_nxt = MD_WAIT;
          w_cnt_nxt   = CNT_W'(MULDIV_LAT - 2);
        end
      end
      MD_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = MD_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      // The mul/div leaves EX this cycle; muldiv_e still reflects it, so it is ignored.
      MD_DONE: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
`else
  // No mul/div sequencing: the input and latency parameter are intentionally unused.
  logic w_unused_muldiv;
  assign w_unused_muldiv = muldiv_e | (MULDIV_LAT < 2);
  assign w_md_stall      = 1'b0;
`endif

  // Priority: mul/div stall (EX is occupied, lu/pcsrc cannot be genuine) >
  // taken branch (redirect must proceed, so no fetch/decode hold) > load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    md_busy = 1'b0;
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    if (rst) begin
      fwd_a_e = w_fwd_a;
      fwd_b_e = w_fwd_b;
      if (w_md_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
        md_busy = 1'b1;
      end else if (pcsrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (w_lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed cases followed by random
// stimulus compared against a cycle-count reference model. Adapts to whether
// PIPE_HAZARD_MULDIV_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwrite_m, regwrite_w, load_e, pcsrc_e, muldiv_e;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, md_busy;
  logic [1:0] fwd_a_e, fwd_b_e;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: stall cycles still owed, and the one-cycle pass-through after a stall.
  int md_left = 0;
  bit md_cool = 1'b0;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MULDIV_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rs1_e      (rs1_e),
    .rs2_e      (rs2_e),
    .rd_e       (rd_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .load_e     (load_e),
    .pcsrc_e    (pcsrc_e),
    .muldiv_e   (muldiv_e),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .stall_e    (stall_e),
    .stall_m    (stall_m),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .flush_m    (flush_m),
    .fwd_a_e    (fwd_a_e),
    .fwd_b_e    (fwd_b_e),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  wire [11:0] dut_outs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                          flush_m, md_busy, fwd_a_e, fwd_b_e};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (regwrite_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
    if (regwrite_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_md_active();
`ifdef PIPE_HAZARD_MULDIV_EN
    return (md_left > 0) || (!md_cool && muldiv_e);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] ref_outs();
    bit md, lu, sfd, fd, fe;
    if (!rst) return 12'd0;
    md  = ref_md_active();
    lu  = load_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    sfd = md || (!pcsrc_e && lu);
    fd  = !md && pcsrc_e;
    fe  = !md && (pcsrc_e || lu);
    return {sfd, sfd, md, 1'b0, fd, fe, md, md, ref_fwd(rs1_e), ref_fwd(rs2_e)};
  endfunction

  // Advance the reference across one rising edge using the inputs of the cycle just ended.
  task automatic ref_update();
`ifdef PIPE_HAZARD_MULDIV_EN
    if (!rst) begin
      md_left = 0;
      md_cool = 1'b0;
    end else begin
      if (md_left == 0 && !md_cool && muldiv_e) md_left = LAT;
      if (md_left > 0) begin
        md_left--;
        md_cool = (md_left == 0);
      end else begin
        md_cool = 1'b0;
      end
    end
`endif
  endtask

  // Called just after a falling edge with inputs set: compare, cross the rising edge, return at the next falling edge.
  task automatic tick(input string tag);
    #1;
    check(tag, {20'd0, dut_outs}, {20'd0, ref_outs()});
    @(posedge clk);
    ref_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e  = '0; rd_m  = '0; rd_w  = '0;
    regwrite_m = 1'b0; regwrite_w = 1'b0;
    load_e = 1'b0; pcsrc_e = 1'b0; muldiv_e = 1'b0;
  endtask

  initial begin
    clear_inputs();
    regwrite_m = 1'b1; rd_m = 5'd2; rs1_e = 5'd2; load_e = 1'b1; rd_e = 5'd2; rs1_d = 5'd2;
    @(negedge clk);
    #1;
    check("reset_outs", {20'd0, dut_outs}, 32'd0);
    @(posedge clk);
    ref_update();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    tick("post_reset");

    // Forwarding priority: MEM, then WB, then register file.
    regwrite_m = 1'b1; rd_m = 5'd5; regwrite_w = 1'b1; rd_w = 5'd5; rs1_e = 5'd5;
    #1 check("fwd_mem", {30'd0, fwd_a_e}, 32'd2);
    rd_m = 5'd0;
    #1 check("fwd_wb", {30'd0, fwd_a_e}, 32'd1);
    rd_w = 5'd0;
    #1 check("fwd_rf", {30'd0, fwd_a_e}, 32'd0);
    rs2_e = 5'd9; rd_w = 5'd9;
    #1 check("fwd_b_wb", {30'd0, fwd_b_e}, 32'd1);
    tick("fwd_cycle");
    clear_inputs();

    // Load-use: one bubble, then clean.
    load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
    #1 check("lu_set", {29'd0, stall_f, stall_d, flush_e}, 32'd7);
    tick("lu_cycle");
    load_e = 1'b0;
    #1 check("lu_gone", {29'd0, stall_f, stall_d, flush_e}, 32'd0);
    load_e = 1'b1; rd_e = 5'd0; rs2_d = 5'd0;
    #1 check("lu_x0", {20'd0, dut_outs}, 32'd0);
    tick("lu_x0_cycle");
    clear_inputs();

    // Branch overrides load-use.
    pcsrc_e = 1'b1; load_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
    #1 check("br_over_lu", {28'd0, flush_d, flush_e, stall_f, stall_d}, 32'hC);
    tick("br_cycle");
    clear_inputs();

`ifdef PIPE_HAZARD_MULDIV_EN
    // Held mul/div: LAT stall cycles, one free cycle, then a fresh stall.
    muldiv_e = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("md_busy_seq", {31'd0, md_busy}, {31'd0, ((i % 5) != 4)});
      check("md_set_seq", {28'd0, stall_f, stall_d, stall_e, flush_m},
            ((i % 5) != 4) ? 32'hF : 32'h0);
      tick("md_model");
    end
    clear_inputs();
    tick("md_idle");

    // Reset in the second MD_WAIT cycle aborts the stall at once.
    muldiv_e = 1'b1;
    tick("md_rst_run");
    tick("md_rst_wait1");
    #1 check("md_rst_busy_before", {31'd0, md_busy}, 32'd1);
    rst = 1'b0;
    #1 check("md_rst_outs", {20'd0, dut_outs}, 32'd0);
    tick("md_rst_cycle");
    muldiv_e = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("md_after_rst", {28'd0, md_busy, stall_f, stall_e, flush_m}, 32'd0);
      tick("md_after_rst_model");
    end
`else
    // Without the mul/div option the request is ignored entirely.
    muldiv_e = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 check("nomd_quiet", {29'd0, md_busy, stall_e, flush_m}, 32'd0);
      tick("nomd_model");
    end
    clear_inputs();
`endif

    // Random traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      rst        = ($urandom_range(0, 149) != 0);
      rs1_d      = 5'($urandom_range(0, 7));
      rs2_d      = 5'($urandom_range(0, 7));
      rs1_e      = 5'($urandom_range(0, 7));
      rs2_e      = 5'($urandom_range(0, 7));
      rd_e       = 5'($urandom_range(0, 7));
      rd_m       = 5'($urandom_range(0, 7));
      rd_w       = 5'($urandom_range(0, 7));
      regwrite_m = 1'($urandom_range(0, 1));
      regwrite_w = 1'($urandom_range(0, 1));
      load_e     = ($urandom_range(0, 2) == 0);
      pcsrc_e    = ($urandom_range(0, 4) == 0);
      muldiv_e   = ($urandom_range(0, 5) == 0);
      // A mul/div entering EX cannot share EX with a load or a branch.
      if (muldiv_e && md_left == 0 && !md_cool) begin
        load_e  = 1'b0;
        pcsrc_e = 1'b0;
      end
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
